// File: rtl/module_keypad_scan.sv
// 4x4 active-low matrix keypad scanner: one row per clk_div rising edge, frame-level
// classification (none / single key / multiple keys) and debounce over DEBOUNCE_SCANS frames.
module module_keypad_scan #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } result_t;

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS);

  function automatic logic [3:0] key_map(input logic [3:0] pos);
    case (pos)
      4'd0:    key_map = 4'h1;
      4'd1:    key_map = 4'h2;
      4'd2:    key_map = 4'h3;
      4'd3:    key_map = 4'hA;
      4'd4:    key_map = 4'h4;
      4'd5:    key_map = 4'h5;
      4'd6:    key_map = 4'h6;
      4'd7:    key_map = 4'hB;
      4'd8:    key_map = 4'h7;
      4'd9:    key_map = 4'h8;
      4'd10:   key_map = 4'h9;
      4'd11:   key_map = 4'hC;
      4'd12:   key_map = 4'hE;
      4'd13:   key_map = 4'h0;
      4'd14:   key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  logic       clk_div_q;
  logic [3:0] col_meta;
  logic [3:0] col_sync;
  logic [1:0] row_idx;
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;
  result_t    prev_kind;
  logic [3:0] prev_code;
  logic [3:0] stable_cnt;

  logic       tick;
  logic       frame_end;
  logic [2:0] row_cnt;
  logic [1:0] row_col;
  logic [3:0] row_code;
  logic [2:0] sum;
  logic [3:0] frame_code;
  result_t    frame_kind;
  logic       same;
  logic       accept;

  assign tick      = clk_div & ~clk_div_q;
  assign frame_end = tick && (row_idx == 2'd3);
  assign row_out   = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_div_q <= 1'b0;
      col_meta  <= 4'b1111;
      col_sync  <= 4'b1111;
    end else begin
      clk_div_q <= clk_div;
      col_meta  <= col_in;
      col_sync  <= col_meta;
    end
  end

  // The accumulator saturates at 2 pressed bits: beyond that the frame is MULTI regardless.
  always_comb begin
    row_cnt = 3'd0;
    row_col = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_sync[c]) begin
        row_cnt = row_cnt + 3'd1;
        row_col = 2'(c);
      end
    end
    row_code   = key_map({row_idx, row_col});
    sum        = {1'b0, acc_cnt} + row_cnt;
    frame_code = (acc_cnt == 2'd1) ? acc_code : row_code;
    if (sum == 3'd0)      frame_kind = RES_NONE;
    else if (sum == 3'd1) frame_kind = RES_KEY;
    else                  frame_kind = RES_MULTI;
    same   = (frame_kind == prev_kind) && ((frame_kind != RES_KEY) || (frame_code == prev_code));
    accept = frame_end && same && (stable_cnt == STABLE_MAX - 4'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx    <= 2'd0;
      acc_cnt    <= 2'd0;
      acc_code   <= 4'd0;
      prev_kind  <= RES_NONE;
      prev_code  <= 4'd0;
      stable_cnt <= 4'd0;
    end else if (tick) begin
      row_idx <= row_idx + 2'd1;
      if (frame_end) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'd0;
        if (same) begin
          if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 4'd1;
        end else begin
          prev_kind  <= frame_kind;
          prev_code  <= frame_code;
          stable_cnt <= 4'd1;
        end
      end else begin
        acc_cnt  <= (sum >= 3'd2) ? 2'd2 : sum[1:0];
        acc_code <= frame_code;
      end
    end
  end

  // key_valid is a one-cycle strobe with no back-pressure; key_code is valid with it and
  // holds until the next accepted key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (accept) begin
        if (frame_kind == RES_KEY) begin
          if (!(key_held && (key_code == frame_code))) begin
            key_code  <= frame_code;
            key_held  <= 1'b1;
            key_valid <= 1'b1;
          end
        end else if (frame_kind == RES_NONE) begin
          key_held <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_module_keypad_scan.sv
// Bench for module_keypad_scan: frame-level keypad stimulus, a reference model of the
// frame/debounce rules, and a monitor that checks outputs against queued expectations.
module tb_module_keypad_scan;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_div = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;
  logic [2:0]  div_cnt = '0;
  logic        div_prev = 1'b0;
  int          ticks = 0;
  int          frames_done = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic [19:0] exp_pulse_q[$];
  logic [4:0]  exp_state_q[$];

  int          prev_res;
  int          run_len;
  int          frame_idx;
  logic        m_held;
  logic [3:0]  m_code;
  logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  module_keypad_scan #(.DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      div_cnt = div_cnt + 3'd1;
      clk_div = div_cnt[2];
    end
  end

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: classify a whole frame, track run length of identical results
  task automatic model_reset();
    prev_res  = -1;
    run_len   = 0;
    frame_idx = 0;
    m_held    = 1'b0;
    m_code    = 4'd0;
    exp_pulse_q.delete();
    exp_state_q.delete();
  endtask

  task automatic model_frame(input logic [15:0] m);
    int n = 0;
    int pos = 0;
    int res;
    for (int i = 0; i < 16; i++) if (m[i]) begin n++; pos = i; end
    if (n == 0)      res = -1;
    else if (n == 1) res = int'(kmap[pos]);
    else             res = -2;
    if (res == prev_res) run_len++;
    else begin prev_res = res; run_len = 1; end
    frame_idx++;
    if (run_len == DEB) begin
      if (res >= 0) begin
        if (!(m_held && m_code == 4'(res))) exp_pulse_q.push_back({4'(res), 16'(frame_idx)});
        m_code = 4'(res);
        m_held = 1'b1;
      end else if (res == -1) begin
        m_held = 1'b0;
      end
    end
    exp_state_q.push_back({m_held, m_code});
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [15:0] m);
    int start;
    bit done = 1'b0;
    pressed = m;
    model_frame(m);
    start = frames_done;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (frames_done != start) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_timeout: got no frame end, expected one within 100 cycles at %0t", $time);
    end
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic release_reset();
    for (int i = 0; i < 20 && div_cnt != 3'd0; i++) step();
    rst = 1'b0;
  endtask

  // tick/frame tracker derived from the bench's own clk_div
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        ticks = 0;
        frames_done = 0;
        div_prev = 1'b0;
      end else begin
        if (clk_div && !div_prev) begin
          ticks++;
          if (ticks % 4 == 0) frames_done++;
        end
        div_prev = clk_div;
      end
    end
  end

  // scoreboard monitor
  initial begin
    int last = 0;
    logic [19:0] p;
    logic [4:0] s;
    logic [3:0] er;
    bit fe;
    bit exp_v;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        last = 0;
      end else begin
        er = ~(4'b0001 << (ticks % 4));
        check("row_out", int'(row_out), int'(er));
        fe = (frames_done != last);
        exp_v = fe && (exp_pulse_q.size() > 0) && (int'(exp_pulse_q[0][15:0]) == frames_done);
        check("key_valid", int'(key_valid), int'(exp_v));
        if (exp_v) begin
          p = exp_pulse_q.pop_front();
          check("pulse_code", int'(key_code), int'(p[19:16]));
        end
        if (fe) begin
          last = frames_done;
          if (exp_state_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL state_queue: got frame end %0d, expected no frame end", frames_done);
          end else begin
            s = exp_state_q.pop_front();
            check("key_held", int'(key_held), int'(s[4]));
            check("key_code", int'(key_code), int'(s[3:0]));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m;
    int r;
    model_reset();
    repeat (3) step();
    check("rst_row_out", int'(row_out), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    release_reset();

    // press and release '5'
    repeat (6) run_frame(16'h1 << 5);
    repeat (5) run_frame(16'h0);

    // bouncing '9'
    run_frame(16'h1 << 10); run_frame(16'h0);
    run_frame(16'h1 << 10); run_frame(16'h0);
    repeat (4) run_frame(16'h1 << 10);
    repeat (4) run_frame(16'h0);

    // '1' and '2' together
    repeat (8) run_frame(16'h0003);
    repeat (4) run_frame(16'h0);

    // roll '#' to 'D'
    repeat (4) run_frame(16'h1 << 14);
    repeat (5) run_frame(16'h1 << 15);

    // reset mid-frame while 'D' is held
    for (int i = 0; i < 40 && (ticks % 4) != 2; i++) step();
    assert_reset();
    #1;
    check("mid_rst_row_out", int'(row_out), 4'b1110);
    check("mid_rst_key_valid", int'(key_valid), 0);
    check("mid_rst_key_held", int'(key_held), 0);
    check("mid_rst_key_code", int'(key_code), 0);
    repeat (2) step();
    pressed = 16'h0;
    release_reset();
    repeat (2) run_frame(16'h0);

    // reset mid-debounce with '0' held across it
    repeat (2) run_frame(16'h1 << 13);
    assert_reset();
    repeat (3) step();
    release_reset();
    repeat (5) run_frame(16'h1 << 13);
    repeat (4) run_frame(16'h0);

    // randomized frames, biased towards repeats so runs reach the debounce length
    m = 16'h0;
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 9);
      if (r == 6 || r == 7) m = 16'h1 << $urandom_range(0, 15);
      else if (r == 8) m = 16'h0;
      else if (r == 9) m = (16'h1 << $urandom_range(0, 7)) | (16'h1 << $urandom_range(8, 15));
      run_frame(m);
    end
    repeat (5) run_frame(16'h0);

    check("pulse_q_empty", exp_pulse_q.size(), 0);
    check("state_q_empty", exp_state_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
